// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// This block arbitrates between two requesters that want to write an 8-entry,
// 8-bit register file through a single write port. It also sequences a clear
// sweep that zeroes every register after reset and whenever init_req is seen.
//
// The core requester normally has priority. If the debug requester has been
// blocked for STARVE_LIMIT core transfers in a row, it is granted one slot
// ahead of the core.
//
// Ports
//   clk            : clock; all state changes on the rising edge
//   rst_n          : asynchronous, active-low reset
//   core_wr_valid  : core writeback request
//   core_wr_dst    : core destination register index (3 bits)
//   core_wr_data   : core write data (8 bits)
//   core_wr_ready  : core request accepted this cycle when high with valid
//   dbg_wr_valid   : debug/loader write request
//   dbg_wr_dst     : debug destination register index
//   dbg_wr_data    : debug write data
//   dbg_wr_ready   : debug request accepted this cycle when high with valid
//   init_req       : start a clear sweep of r0..r7 (ignored while sweeping)
//   busy           : high while the clear sweep runs
//   rf_we          : registered register-file write enable
//   rf_dst         : registered register-file write index
//   rf_in          : registered register-file write data
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       core_wr_valid,
  input  logic [2:0] core_wr_dst,
  input  logic [7:0] core_wr_data,
  output logic       core_wr_ready,
  input  logic       dbg_wr_valid,
  input  logic [2:0] dbg_wr_dst,
  input  logic [7:0] dbg_wr_data,
  output logic       dbg_wr_ready,
  input  logic       init_req,
  output logic       busy,
  output logic       rf_we,
  output logic [2:0] rf_dst,
  output logic [7:0] rf_in
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [2:0] w_idx_next;
  logic [2:0] r_starve_cnt;
  logic [2:0] w_starve_next;
  logic       r_we;
  logic       w_we_next;
  logic [2:0] r_dst;
  logic [2:0] w_dst_next;
  logic [7:0] r_in;
  logic [7:0] w_in_next;

  logic       w_force;
  logic       w_core_ready;
  logic       w_dbg_ready;
  logic       w_core_xfer;
  logic       w_dbg_xfer;

  // The debug requester has waited long enough and now takes priority.
  assign w_force = (r_starve_cnt >= LIMIT);

  // State, sweep index, starvation counter and write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_idx        <= 3'd0;
      r_starve_cnt <= 3'd0;
      r_we         <= 1'b0;
      r_dst        <= 3'd0;
      r_in         <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_starve_cnt <= w_starve_next;
      r_we         <= w_we_next;
      r_dst        <= w_dst_next;
      r_in         <= w_in_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_starve_next = r_starve_cnt;
    w_we_next     = 1'b0;
    w_dst_next    = r_dst;  // hold the last address/data when idle
    w_in_next     = r_in;
    w_core_ready  = 1'b0;
    w_dbg_ready   = 1'b0;
    w_core_xfer   = 1'b0;
    w_dbg_xfer    = 1'b0;

    case (r_state)
      ST_INIT: begin
        // One register cleared per cycle. init_req is ignored here, so a
        // sweep that is already running is never restarted.
        w_we_next     = 1'b1;
        w_dst_next    = r_idx;
        w_in_next     = 8'h00;
        w_idx_next    = r_idx + 3'd1;
        w_starve_next = 3'd0;
        if (r_idx == 3'd7) begin
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        // Both ready signals include !init_req, so no transfer can occur in
        // the cycle that starts a sweep. When both requesters are valid the
        // two readies are complements of each other on w_force, so at most
        // one transfer happens per cycle.
        w_core_ready = !(dbg_wr_valid && w_force) && !init_req;
        w_dbg_ready  = (!core_wr_valid || w_force) && !init_req;
        w_core_xfer  = core_wr_valid && w_core_ready;
        w_dbg_xfer   = dbg_wr_valid && w_dbg_ready;

        if (init_req) begin
          w_state_next  = ST_INIT;
          w_idx_next    = 3'd0;
          w_starve_next = 3'd0;
        end else begin
          if (w_core_xfer) begin
            w_we_next  = 1'b1;
            w_dst_next = core_wr_dst;
            w_in_next  = core_wr_data;
          end else if (w_dbg_xfer) begin
            w_we_next  = 1'b1;
            w_dst_next = dbg_wr_dst;
            w_in_next  = dbg_wr_data;
          end

          // The counter tracks only an unbroken run of debug blocking. It
          // clears once debug is served or debug stops asking.
          if (!dbg_wr_valid || w_dbg_xfer) begin
            w_starve_next = 3'd0;
          end else if (w_core_xfer) begin
            w_starve_next = (r_starve_cnt >= LIMIT) ? LIMIT
                                                    : r_starve_cnt + 3'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_INIT;
        w_idx_next   = 3'd0;
      end
    endcase
  end

  assign busy          = (r_state == ST_INIT);
  assign core_wr_ready = w_core_ready;
  assign dbg_wr_ready  = w_dbg_ready;
  assign rf_we         = r_we;
  assign rf_dst        = r_dst;
  assign rf_in         = r_in;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1..7: consecutive debug-blocked transfers before the debug requester is forced ahead of core.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port core_wr_valid, input, 1: core writeback request.
REQ-005 SHALL have port core_wr_dst, input, 3: core destination register index.
REQ-006 SHALL have port core_wr_data, input, 8: core write data.
REQ-007 SHALL have port core_wr_ready, output, 1: core request accepted this cycle when high together with valid.
REQ-008 SHALL have ports dbg_wr_valid (in, 1), dbg_wr_dst (in, 3), dbg_wr_data (in, 8) and dbg_wr_ready (out, 1): the debug/loader requester, with the same meanings as the core ports.
REQ-009 SHALL have port init_req, input, 1: request a clear sweep of all eight registers.
REQ-010 SHALL have port busy, output, 1: high while the clear sweep runs.
REQ-011 SHALL have ports rf_we (out, 1), rf_dst (out, 3) and rf_in (out, 8): the register-file write port, all registered.

Function
REQ-012 SHALL implement states INIT and RUN, with a 3-bit sweep index idx and a 3-bit starvation counter starve_cnt.
REQ-013 In INIT, each cycle SHALL register rf_we=1, rf_dst=idx and rf_in=0x00, increment idx, and hold both readies low.
REQ-014 The INIT cycle with idx=7 SHALL be followed by RUN, giving exactly 8 INIT cycles that clear r0..r7 in ascending order.
REQ-015 busy SHALL be combinational and equal to (state==INIT).
REQ-016 init_req in RUN SHALL move the block to INIT with idx=0 next cycle; no handshake transfer occurs in that cycle and both readies are low.
REQ-017 init_req during INIT SHALL be ignored, with no sweep restart.
REQ-018 In RUN, with force defined as (starve_cnt >= STARVE_LIMIT): core_wr_ready SHALL be combinational and equal to !(dbg_wr_valid && force) && !init_req.
REQ-019 In RUN, dbg_wr_ready SHALL be combinational and equal to (!core_wr_valid || force) && !init_req.
REQ-020 A transfer SHALL occur when valid && ready; core and debug transfers SHALL never occur in the same cycle.
REQ-021 A transfer in cycle N SHALL produce rf_we=1, rf_dst=dst and rf_in=data in cycle N+1 (1-cycle latency); with no transfer and not in INIT, rf_we=0 and rf_dst/rf_in hold their previous values.
REQ-022 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each core transfer while dbg_wr_valid=1.
REQ-023 starve_cnt SHALL clear on a debug transfer, on any cycle with dbg_wr_valid=0, and on entry to INIT.
REQ-024 Requesters SHALL hold valid/dst/data stable until transfer; the block SHALL NOT check this, and dropping valid before transfer SHALL simply withdraw the request.
REQ-025 Back-to-back transfers (one per cycle) SHALL be supported with no bubble.

Reset
REQ-026 While rst_n=0, outputs SHALL immediately be rf_we=0, rf_dst=0, rf_in=0x00, state=INIT, idx=0, starve_cnt=0, busy=1, and both readies=0.
REQ-027 On the first clk edge after rst_n rises, the block SHALL begin the clear sweep, making reset imply all registers = 0 after 8 cycles.
REQ-028 Reset asserted mid-sweep or mid-transfer SHALL abort immediately; the sweep SHALL restart from idx=0 and no partial or pending write is emitted.

Verification
REQ-029 Release rst_n -> rf_we=1 for 8 consecutive cycles with rf_dst 0,1,...,7 and rf_in=0; busy low and core_wr_ready=1 from the 9th cycle.
REQ-030 In RUN, core_wr_valid=1, dst=3, data=0xA5 for one cycle -> next cycle rf_we=1, rf_dst=3, rf_in=0xA5; following cycle rf_we=0.
REQ-031 core_wr_valid and dbg_wr_valid both held high, STARVE_LIMIT=4 -> 4 core transfers, then dbg_wr_ready=1 and core_wr_ready=0 for 1 cycle (debug wins), then core resumes; the pattern repeats every 5 cycles.
REQ-032 core_wr_valid=0, dbg_wr_valid=1, dst=7, data=0x3C -> dbg_wr_ready=1 same cycle; next cycle rf_we=1, rf_dst=7, rf_in=0x3C.
REQ-033 init_req pulse in RUN while core_wr_valid=1 -> core_wr_ready=0 that cycle, then 8-cycle sweep with busy=1; a second init_req during the sweep does not extend it beyond 8 cycles.
REQ-034 Assert rst_n=0 at sweep idx=4 -> rf_we drops to 0 asynchronously; after release the sweep restarts at rf_dst=0.
